// File: rtl/video_proc_pipe.sv
// Display-path pipeline: raster tracking, zone CC -> colour bars -> 3-tap unsharp mask, fixed 4-cycle latency.
// Build option: define VPP_TP_EN to include the colour-bar generator; otherwise stage 2 is a plain register.
module video_proc_pipe #(
    parameter int CW       = 8,
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cc_en,
    input  logic            tp_en,
    input  logic            um_en,
    input  logic [CW-1:0]   brig,
    input  logic [3:0]      um_gain,
    input  logic            err_clr,
    input  logic [3*CW+2:0] dpi,
    output logic [3*CW+2:0] dpo,
    output logic            err_hlen
);
    localparam int DW = 3*CW + 3;
    localparam int HW = $clog2(H_ACTIVE);
    localparam int VW = $clog2(V_ACTIVE);
    localparam int LW = $clog2(H_ACTIVE + 2);
    localparam int ZQ = H_ACTIVE / 4;

    logic          w_vs, w_de, w_vs_rise;
    logic          r_vs_d, r_de_d, r_err;
    logic          r_sh_cc, r_sh_um, r_cc, r_um;
    logic [CW-1:0] r_sh_brig, r_brig;
    logic [3:0]    r_sh_gain, r_gain;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [LW-1:0] r_len;
    logic [DW-1:0] r_s1, r_s2, r_c, r_l, r_out;
    logic [DW-1:0] w_s1, w_s2, w_s3;
    logic [1:0]    w_zone;
    logic          w_lower;

    assign w_vs      = dpi[DW-1];
    assign w_de      = dpi[DW-3];
    assign w_vs_rise = w_vs & ~r_vs_d;

    // Lower half mirrors the zone order (3-z == ~z) and inverts (MAX-y == ~y) after saturation.
    function automatic logic [CW-1:0] f_cc(input logic [CW-1:0] x, input logic [1:0] z,
                                           input logic lower, input logic [CW-1:0] b);
        logic [1:0]    zz;
        logic [CW-1:0] a, y;
        logic [CW:0]   s;
        zz = lower ? ~z : z;
        a  = (zz[0] ^ zz[1]) ? (b >> 1) : b;
        if (!zz[1]) begin
            s = {1'b0, x} - {1'b0, a};
            y = s[CW] ? '0 : s[CW-1:0];
        end else begin
            s = {1'b0, x} + {1'b0, a};
            y = s[CW] ? '1 : s[CW-1:0];
        end
        return lower ? ~y : y;
    endfunction

    always_comb begin
        if (r_h < HW'(ZQ))            w_zone = 2'd0;
        else if (r_h < HW'(2*ZQ))     w_zone = 2'd1;
        else if (r_h < HW'(3*ZQ))     w_zone = 2'd2;
        else                          w_zone = 2'd3;
    end
    assign w_lower = (r_v >= VW'(V_ACTIVE/2));

    assign w_s1[DW-1 -: 3] = dpi[DW-1 -: 3];
    for (genvar g = 0; g < 3; g++) begin : g_cc
        assign w_s1[g*CW +: CW] = r_cc ? f_cc(dpi[g*CW +: CW], w_zone, w_lower, r_brig)
                                       : dpi[g*CW +: CW];
    end

`ifdef VPP_TP_EN
    logic [HW-1:0] r_h1;
    logic          r_sh_tp, r_tp;
    logic [2:0]    w_bar;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h1    <= '0;
            r_sh_tp <= 1'b0;
            r_tp    <= 1'b0;
        end else begin
            r_h1    <= r_h;
            r_sh_tp <= tp_en;
            if (w_vs_rise) r_tp <= r_sh_tp;
        end
    end

    always_comb begin
        w_bar = '0;
        for (int k = 1; k < 8; k++)
            if (r_h1 >= HW'(k*(H_ACTIVE/8))) w_bar = 3'(k);
    end
    // Bar order white..black maps to RGB = {~b1, ~b2, ~b0} of the bar index.
    assign w_s2 = r_tp ? {r_s1[DW-1 -: 3], {CW{~w_bar[1]}}, {CW{~w_bar[2]}}, {CW{~w_bar[0]}}}
                       : r_s1;
`else
    logic w_unused_tp;
    assign w_unused_tp = tp_en;
    assign w_s2        = r_s1;
`endif

    // Window: l = r_l, c = r_c, r = r_s2; neighbours outside den replicate the centre.
    assign w_s3[DW-1 -: 3] = r_c[DW-1 -: 3];
    for (genvar g = 0; g < 3; g++) begin : g_um
        logic [CW-1:0]        w_c, w_l, w_r, w_o;
        logic signed [CW+1:0] w_d;
        logic signed [CW+5:0] w_p, w_y;
        assign w_c = r_c[g*CW +: CW];
        assign w_l = r_l[DW-3]  ? r_l[g*CW +: CW]  : w_c;
        assign w_r = r_s2[DW-3] ? r_s2[g*CW +: CW] : w_c;
        assign w_d = $signed({1'b0, w_c, 1'b0}) - $signed({2'b0, w_l}) - $signed({2'b0, w_r});
        assign w_p = (CW+6)'(w_d) * (CW+6)'($signed({1'b0, r_gain}));
        assign w_y = $signed({6'b0, w_c}) + (w_p >>> 2);
        assign w_o = w_y[CW+5] ? '0 : ((|w_y[CW+4:CW]) ? '1 : w_y[CW-1:0]);
        assign w_s3[g*CW +: CW] = (r_um && r_c[DW-3]) ? w_o : w_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d    <= 1'b0;
            r_de_d    <= 1'b0;
            r_err     <= 1'b0;
            r_sh_cc   <= 1'b0;
            r_sh_um   <= 1'b0;
            r_cc      <= 1'b0;
            r_um      <= 1'b0;
            r_sh_brig <= '0;
            r_brig    <= '0;
            r_sh_gain <= '0;
            r_gain    <= '0;
            r_h       <= '0;
            r_v       <= '0;
            r_len     <= '0;
            r_s1      <= '0;
            r_s2      <= '0;
            r_c       <= '0;
            r_l       <= '0;
            r_out     <= '0;
        end else begin
            r_vs_d    <= w_vs;
            r_de_d    <= w_de;
            r_sh_cc   <= cc_en;
            r_sh_um   <= um_en;
            r_sh_brig <= brig;
            r_sh_gain <= um_gain;
            if (w_vs_rise) begin
                r_cc   <= r_sh_cc;
                r_um   <= r_sh_um;
                r_brig <= r_sh_brig;
                r_gain <= r_sh_gain;
            end

            if (w_de) begin
                if (r_h == HW'(H_ACTIVE-1)) begin
                    r_h <= '0;
                    r_v <= (r_v == VW'(V_ACTIVE-1)) ? '0 : r_v + VW'(1);
                end else begin
                    r_h <= r_h + HW'(1);
                end
            end else if (w_vs) begin
                r_h <= '0;
                r_v <= '0;
            end

            // Run length saturates so over-long lines can never alias back to H_ACTIVE.
            if (w_de)
                r_len <= !r_de_d ? LW'(1) : ((r_len == '1) ? r_len : r_len + LW'(1));
            if (r_de_d && !w_de && (r_len != LW'(H_ACTIVE)))
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;

            r_s1  <= w_s1;
            r_s2  <= w_s2;
            r_c   <= r_s2;
            r_l   <= r_c;
            r_out <= w_s3;
        end
    end

    assign dpo      = r_out;
    assign err_hlen = r_err;
endmodule

// File: tb/tb_video_proc_pipe.sv
// Scoreboard bench for video_proc_pipe (CW=8, 16x4 raster); behavioural model predicts every output.
module tb_video_proc_pipe;
    localparam int CW = 8, H = 16, V = 4, DW = 27;

    logic          clk = 1'b0;
    logic          rst_n, cc_en, tp_en, um_en, err_clr;
    logic [7:0]    brig;
    logic [3:0]    um_gain;
    logic [DW-1:0] dpi, dpo;
    logic          err_hlen;

    always #5 clk = ~clk;

    video_proc_pipe #(.CW(CW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rst_n(rst_n), .cc_en(cc_en), .tp_en(tp_en), .um_en(um_en),
        .brig(brig), .um_gain(um_gain), .err_clr(err_clr),
        .dpi(dpi), .dpo(dpo), .err_hlen(err_hlen)
    );

    typedef struct { logic [DW-1:0] s2; bit um; int g; } hist_t;
    typedef struct { int idx; logic [DW-1:0] v; } exp_t;

    int n_vec = 0, n_err = 0;
    hist_t hist[$];
    exp_t  sbq[$];
    int    cyc, m_h, m_v, m_len;
    bit    m_vs_d, m_de_d, m_err;
    bit    sh_cc, sh_tp, sh_um, act_cc, act_tp, act_um;
    int    sh_b, sh_g, act_b, act_g;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    logic [23:0] q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int clamp8(int y);
        return (y < 0) ? 0 : ((y > 255) ? 255 : y);
    endfunction

    function automatic logic [7:0] m_cc(int x, int h, int v, int b);
        int z, a, y;
        bit lo;
        lo = (v >= V/2);
        z  = h / (H/4);
        if (lo) z = 3 - z;
        case (z)
            0:       a = -b;
            1:       a = -(b/2);
            2:       a = b/2;
            default: a = b;
        endcase
        y = clamp8(x + a);
        if (lo) y = 255 - y;
        return 8'(y);
    endfunction

    function automatic logic [DW-1:0] m_um(int j);
        logic [DW-1:0] c, l, r, o;
        int d, p;
        c = hist[j].s2;
        if (!hist[j].um || !c[24]) return c;
        l = (j > 0 && hist[j-1].s2[24]) ? hist[j-1].s2 : c;
        r = hist[j+1].s2[24] ? hist[j+1].s2 : c;
        o = c;
        for (int ch = 0; ch < 3; ch++) begin
            d = 2*int'(c[ch*8 +: 8]) - int'(l[ch*8 +: 8]) - int'(r[ch*8 +: 8]);
            p = d * hist[j].g;
            o[ch*8 +: 8] = 8'(clamp8(int'(c[ch*8 +: 8]) + (p >>> 2)));
        end
        return o;
    endfunction

    task automatic model_clear();
        hist.delete(); sbq.delete();
        cyc = 0; m_h = 0; m_v = 0; m_len = 0;
        m_vs_d = 0; m_de_d = 0; m_err = 0;
        sh_cc = 0; sh_tp = 0; sh_um = 0; sh_b = 0; sh_g = 0;
        act_cc = 0; act_tp = 0; act_um = 0; act_b = 0; act_g = 0;
    endtask

    // Called at a falling edge: check outputs, drive one pixel, advance the model one clock.
    task automatic tick(input bit vs, input bit hs, input bit de, input logic [23:0] rgb);
        exp_t          e;
        hist_t         hh;
        logic [DW-1:0] s2;
        if (sbq.size() > 0 && sbq[0].idx == cyc - 4) begin
            e = sbq.pop_front();
            if (e.v[24]) chk("dpo", 32'(dpo), 32'(e.v));
            else         chk("dpo_sync", 32'(dpo[26:24]), 32'(e.v[26:24]));
        end
        chk("err_hlen", 32'(err_hlen), 32'(m_err));
        dpi = {vs, hs, de, rgb};
        s2  = dpi;
        if (act_cc)
            for (int ch = 0; ch < 3; ch++) s2[ch*8 +: 8] = m_cc(int'(rgb[ch*8 +: 8]), m_h, m_v, act_b);
`ifdef VPP_TP_EN
        if (act_tp) s2[23:0] = bars[m_h/2];
`endif
        hh.s2 = s2; hh.um = act_um; hh.g = act_g;
        hist.push_back(hh);
        if (cyc >= 1) begin
            e.idx = cyc - 1;
            e.v   = m_um(cyc - 1);
            sbq.push_back(e);
        end
        if (m_de_d && !de && m_len != H) m_err = 1;
        else if (err_clr)                m_err = 0;
        if (de) m_len = m_de_d ? m_len + 1 : 1;
        m_de_d = de;
        if (de) begin
            if (m_h == H-1) begin m_h = 0; m_v = (m_v == V-1) ? 0 : m_v + 1; end
            else m_h++;
        end else if (vs) begin
            m_h = 0; m_v = 0;
        end
        if (vs && !m_vs_d) begin
            act_cc = sh_cc; act_tp = sh_tp; act_um = sh_um; act_b = sh_b; act_g = sh_g;
        end
        sh_cc = cc_en; sh_tp = tp_en; sh_um = um_en; sh_b = int'(brig); sh_g = int'(um_gain);
        m_vs_d = vs;
        cyc++;
        @(negedge clk);
    endtask

    task automatic blank(input int n, input bit vs, input bit hs);
        repeat (n) tick(vs, hs, 1'b0, 24'($urandom));
    endtask

    task automatic vframe();
        blank(1, 0, 0); blank(3, 1, 0); blank(2, 0, 0);
    endtask

    task automatic line(input logic [23:0] px[$]);
        blank(2, 0, 1);
        foreach (px[i]) tick(1'b0, 1'b0, 1'b1, px[i]);
        blank(2, 0, 0);
    endtask

    task automatic line_fill(input logic [23:0] v, input int n);
        q.delete();
        repeat (n) q.push_back(v);
        line(q);
    endtask

    task automatic line_rand();
        q.delete();
        repeat (H) q.push_back(24'($urandom));
        line(q);
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        chk("rst_dpo", 32'(dpo), 32'h0);
        chk("rst_err", 32'(err_hlen), 32'h0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        dpi = '0; cc_en = 0; tp_en = 0; um_en = 0; err_clr = 0; brig = '0; um_gain = '0;
        rst_n = 1'b1;
        @(negedge clk);
        reset_now();

        // pass-through, latency and sync tracking
        vframe();
        q.delete(); q.push_back(24'h123456);
        repeat (H-1) q.push_back(24'($urandom));
        line(q);
        line_rand(); line_rand();

        // zone correction, then a mid-frame brig change that must wait for vsync
        cc_en = 1; brig = 8'h40;
        vframe();
        line_fill(24'h808080, H);
        q.delete();
        for (int i = 0; i < H; i++) q.push_back(i >= 12 ? 24'hF0F0F0 : 24'h808080);
        line(q);
        brig = 8'h10;
        line_fill(24'h808080, H);
        line_rand();
        vframe();
        line_fill(24'h808080, H); line_rand(); line_fill(24'h808080, H); line_rand();

        // unsharp mask
        cc_en = 0; um_en = 1; um_gain = 4'd4;
        vframe();
        q.delete();
        q.push_back(24'h404040); q.push_back(24'h404040); q.push_back(24'h808080);
        repeat (H-3) q.push_back(24'h404040);
        line(q);
        line_rand(); line_rand(); line_rand();

        // colour bars (pass-through when the generator is not built)
        tp_en = 1; um_en = 0;
        vframe();
        line_rand(); line_rand(); line_rand(); line_rand();

        // random control mixes
        repeat (3) begin
            cc_en = 1'($urandom); tp_en = 1'($urandom); um_en = 1'($urandom);
            brig = 8'($urandom); um_gain = 4'($urandom);
            vframe();
            repeat (V) line_rand();
        end

        // reset in the middle of a line
        vframe();
        line_rand();
        blank(2, 0, 1);
        repeat (5) tick(1'b0, 1'b0, 1'b1, 24'($urandom));
        reset_now();
        cc_en = 1; um_en = 1; um_gain = 4'd7; brig = 8'h33;
        vframe();
        repeat (V) line_rand();

        // short line sets the sticky flag; clear; then set and clear together
        line_fill(24'h202020, H-1);
        blank(2, 0, 0);
        err_clr = 1;
        blank(1, 0, 0);
        err_clr = 0;
        blank(2, 0, 0);
        err_clr = 1;
        line_fill(24'h202020, H-1);
        err_clr = 0;
        blank(2, 0, 0);

        vframe();
        line_rand();
        blank(8, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
